// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes and FSM state encoding for the serial ALU
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_AND = 2'b01,
        OP_OR  = 2'b10,
        OP_XOR = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/alu_slice.sv
// rtl/alu_slice.sv - combinational SLICE-bit ALU cell (add/and/or/xor)
module alu_slice
    import alu_pkg::*;
#(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    input  logic [1:0]       M,
    output logic [SLICE-1:0] f,
    output logic             cout,
    output logic             c_msb
);

    logic [SLICE:0] sum;

    // Carry into the MSB is recovered from the MSB sum bit, which works for any SLICE >= 1
    always_comb begin
        sum   = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};
        f     = '0;
        cout  = 1'b0;
        c_msb = 1'b0;
        case (M)
            OP_ADD: begin
                f     = sum[SLICE-1:0];
                cout  = sum[SLICE];
                c_msb = sum[SLICE-1] ^ a[SLICE-1] ^ b[SLICE-1];
            end
            OP_AND:  f = a & b;
            OP_OR:   f = a | b;
            default: f = a ^ b;
        endcase
    end

endmodule

// File: rtl/alu_serial_n.sv
// rtl/alu_serial_n.sv - multi-cycle WIDTH-bit ALU processing SLICE bits per cycle
module alu_serial_n
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       M,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] f,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NS = WIDTH / SLICE;
    localparam int CW = (NS > 1) ? $clog2(NS) : 1;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] work_nxt;
    logic [1:0]       op;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [SLICE-1:0] s_f;
    logic             s_cout;
    logic             s_cmsb;
    logic             accept;
    logic             last;

    // New requests are taken whenever no slices are in flight (IDLE or the DONE cycle)
    assign accept = start && (state != S_RUN);
    assign last   = (state == S_RUN) && (cnt == CW'(NS - 1));
    assign busy   = (state == S_RUN);
    assign done   = (state == S_DONE);

    alu_slice #(.SLICE(SLICE)) u_slice (
        .a     (sh_a[SLICE-1:0]),
        .b     (sh_b[SLICE-1:0]),
        .cin   (carry),
        .M     (op),
        .f     (s_f),
        .cout  (s_cout),
        .c_msb (s_cmsb)
    );

    // Slice results enter at the MSB end so the LSB slice lands at the bottom after NS shifts
    always_comb begin
        work_nxt                  = work >> SLICE;
        work_nxt[WIDTH-1 -: SLICE] = s_f;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (last)  state_nxt = S_DONE;
            S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, slice iteration and result load on the final slice so outputs are valid with done
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_a  <= '0;
            sh_b  <= '0;
            work  <= '0;
            op    <= OP_ADD;
            carry <= 1'b0;
            cnt   <= '0;
            f     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else begin
            if (accept) begin
                sh_a  <= a;
                sh_b  <= b;
                carry <= cin;
                op    <= M;
                cnt   <= '0;
            end else if (state == S_RUN) begin
                sh_a  <= sh_a >> SLICE;
                sh_b  <= sh_b >> SLICE;
                work  <= work_nxt;
                carry <= s_cout;
                cnt   <= cnt + CW'(1);
            end
            if (last) begin
                f    <= work_nxt;
                zero <= (work_nxt == '0);
                cout <= s_cout;
                ovf  <= s_cout ^ s_cmsb;
            end
        end
    end

endmodule

// File: tb/tb_alu_serial_n.sv
// tb/tb_alu_serial_n.sv - directed self-checking bench for alu_serial_n
module tb_alu_serial_n;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [1:0]  M;
    logic        busy;
    logic        done;
    logic [15:0] f;
    logic        cout;
    logic        ovf;
    logic        zero;

    int n_pass = 0;
    int n_total = 0;

    alu_serial_n #(.WIDTH(16), .SLICE(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .M     (M),
        .busy  (busy),
        .done  (done),
        .f     (f),
        .cout  (cout),
        .ovf   (ovf),
        .zero  (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [15:0] va, input logic [15:0] vb,
                          input logic vc, input logic [1:0] vm);
        a   = va;
        b   = vb;
        cin = vc;
        M   = vm;
    endtask

    task automatic check_result(input string tag, input logic [15:0] ef,
                                input logic ec, input logic eo, input logic ez);
        check({tag, ".done"}, {31'd0, done}, 32'd1);
        check({tag, ".busy"}, {31'd0, busy}, 32'd0);
        check({tag, ".f"},    {16'd0, f},    {16'd0, ef});
        check({tag, ".cout"}, {31'd0, cout}, {31'd0, ec});
        check({tag, ".ovf"},  {31'd0, ovf},  {31'd0, eo});
        check({tag, ".zero"}, {31'd0, zero}, {31'd0, ez});
    endtask

    // Start in cycle 0, expect busy in 1..4 with old result held, done in 5
    task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                          input logic vc, input logic [1:0] vm, input logic [15:0] ef,
                          input logic ec, input logic eo, input logic ez);
        logic [15:0] held;
        held = f;
        set_op(va, vb, vc, vm);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            check({tag, ".busy_run"}, {31'd0, busy}, 32'd1);
            check({tag, ".done_run"}, {31'd0, done}, 32'd0);
            check({tag, ".f_hold"},   {16'd0, f},    {16'd0, held});
            tick();
        end
        check_result(tag, ef, ec, eo, ez);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        set_op(16'h0, 16'h0, 1'b0, 2'b00);
        tick();
        tick();
        rst = 1'b0;
        check("reset.busy", {31'd0, busy}, 32'd0);
        check("reset.done", {31'd0, done}, 32'd0);
        check("reset.f",    {16'd0, f},    32'd0);
        check("reset.flags", {29'd0, cout, ovf, zero}, 32'd0);
        tick();

        // Test 1: full carry ripple to zero
        run_op("add_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 2'b00, 16'h0000, 1'b1, 1'b0, 1'b1);
        tick();
        check("t1.done_once", {31'd0, done}, 32'd0);

        // Test 2: signed overflow, cross-slice carry, carry-in only
        run_op("add_7fff_1", 16'h7FFF, 16'h0001, 1'b0, 2'b00, 16'h8000, 1'b0, 1'b1, 1'b0);
        tick();
        run_op("add_0fff_1", 16'h0FFF, 16'h0001, 1'b0, 2'b00, 16'h1000, 1'b0, 1'b0, 1'b0);
        tick();
        run_op("add_cin",    16'h0000, 16'h0000, 1'b1, 2'b00, 16'h0001, 1'b0, 1'b0, 1'b0);
        tick();

        // Test 3: logic ops, cin ignored
        run_op("and", 16'hF0F0, 16'h3C3C, 1'b1, 2'b01, 16'h3030, 1'b0, 1'b0, 1'b0);
        tick();
        run_op("or",  16'hF0F0, 16'h3C3C, 1'b0, 2'b10, 16'hFCFC, 1'b0, 1'b0, 1'b0);
        tick();
        run_op("xor", 16'hAAAA, 16'hAAAA, 1'b1, 2'b11, 16'h0000, 1'b0, 1'b0, 1'b1);
        tick();

        // Test 4: start while busy is ignored and not queued
        set_op(16'h0001, 16'h0001, 1'b0, 2'b00);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        set_op(16'h1234, 16'h1234, 1'b0, 2'b11);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check_result("ignore", 16'h0002, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("ignore.no_second_done", {31'd0, done}, 32'd0);
            check("ignore.idle", {31'd0, busy}, 32'd0);
        end

        // Test 5: back-to-back with start held in the done cycle
        run_op("b2b_first", 16'hF0F0, 16'h3C3C, 1'b0, 2'b01, 16'h3030, 1'b0, 1'b0, 1'b0);
        run_op("b2b_second", 16'h00FF, 16'h0F0F, 1'b0, 2'b11, 16'h0FF0, 1'b0, 1'b0, 1'b0);
        tick();

        // Test 6: reset in cycle 3 (with start also high) aborts the op
        set_op(16'hFFFF, 16'h0001, 1'b0, 2'b00);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check("abort.busy", {31'd0, busy}, 32'd0);
        check("abort.done", {31'd0, done}, 32'd0);
        check("abort.f",    {16'd0, f},    32'd0);
        check("abort.flags", {29'd0, cout, ovf, zero}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("abort.no_done", {31'd0, done}, 32'd0);
            check("abort.no_busy", {31'd0, busy}, 32'd0);
        end
        run_op("after_abort", 16'h1234, 16'h1111, 1'b0, 2'b00, 16'h2345, 1'b0, 1'b0, 1'b0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
